avst_avmm_mmio_bridge: RTL and testbench

AVST_AVMM_MMIO_BRIDGE -- requirements
Module: avst_avmm_mmio_bridge

---
 rtl/ccip_avmm_pkg.sv | 34 +++
 rtl/avmm_bridge_fifo.sv | 82 ++++++++
 rtl/avst_avmm_mmio_bridge.sv | 169 ++++++++++++++++
 tb/tb_avst_avmm_mmio_bridge.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ccip_avmm_pkg.sv
// Shared types and constants for the CCI-P MMIO to Avalon-MM path.
// The command struct is also what the upstream MMIO stage produces.
package ccip_avmm_pkg;

  localparam int CCIP_MMIO_ADDR_WIDTH = 16;
  localparam int CCIP_MMIO_DATA_WIDTH = 64;

  // Command word carried on the Avalon-ST input, MSB first.
  typedef struct packed {
    logic                            is_read;
    logic                            is_32bit;
    logic [CCIP_MMIO_ADDR_WIDTH-1:0] addr;
    logic [CCIP_MMIO_DATA_WIDTH-1:0] write_data;
  } t_avst_input;

  localparam logic [7:0] AVMM_BE_64     = 8'hFF;
  localparam logic [7:0] AVMM_BE_32_LO  = 8'h0F;
  localparam logic [7:0] AVMM_BE_32_HI  = 8'hF0;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } t_bridge_state;

  // A 32-bit access selects the half of the 64-bit word picked by addr[2].
  function automatic logic [7:0] ccip_byteenable(input logic is_32bit,
                                                 input logic addr_bit2);
    if (!is_32bit) begin
      return AVMM_BE_64;
    end
    return addr_bit2 ? AVMM_BE_32_HI : AVMM_BE_32_LO;
  endfunction

endpackage

// File: rtl/avmm_bridge_fifo.sv
// Show-ahead synchronous FIFO with fill count. A push into a full FIFO is
// dropped unless a pop frees an entry in the same cycle. dout_next exposes
// the entry behind the head so the owner can look one command ahead.
module avmm_bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [WIDTH-1:0]         dout_next,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   usedw,
  output logic [$clog2(DEPTH):0]   usedw_next
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] rd_ptr_inc;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty      = (count_q == '0);
  assign full       = (count_q == FULL_CNT);
  assign usedw      = count_q;
  assign usedw_next = count_d;
  assign dout       = mem_q[rd_ptr_q];
  assign dout_next  = mem_q[rd_ptr_inc];

  // Pointer and fill-count bookkeeping for the accepted push/pop this cycle.
  always_comb begin
    push_ok    = push && (!full || pop);
    pop_ok     = pop && !empty;
    rd_ptr_inc = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push_ok) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_inc;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset empties the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are meaningless while the count says empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/avst_avmm_mmio_bridge.sv
// Bridges an Avalon-ST stream of MMIO commands onto an Avalon-MM master
// with pipelined reads, returning read data as an Avalon-ST response stream.
module avst_avmm_mmio_bridge
  import ccip_avmm_pkg::*;
#(
  parameter int AVMM_ADDR_WIDTH   = 16,
  parameter int AVMM_DATA_WIDTH   = 64,
  parameter int CMD_FIFO_DEPTH    = 8,
  parameter int MAX_PENDING_READS = 4
) (
  input  logic                         clk,
  input  logic                         SoftReset,
  input  logic [AVMM_ADDR_WIDTH+AVMM_DATA_WIDTH+1:0] in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [AVMM_DATA_WIDTH-1:0]   out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [AVMM_ADDR_WIDTH-1:0]   avmm_address,
  output logic                         avmm_read,
  output logic                         avmm_write,
  output logic [AVMM_DATA_WIDTH-1:0]   avmm_writedata,
  output logic [AVMM_DATA_WIDTH/8-1:0] avmm_byteenable,
  input  logic                         avmm_waitrequest,
  input  logic [AVMM_DATA_WIDTH-1:0]   avmm_readdata,
  input  logic                         avmm_readdatavalid,
  output logic                         cmd_overflow_err,
  output logic                         rsp_spurious_err
);

  localparam int A         = AVMM_ADDR_WIDTH;
  localparam int D         = AVMM_DATA_WIDTH;
  localparam int BE_W      = D / 8;
  localparam int CMD_W     = A + D + 2;
  localparam int CMD_CNT_W = $clog2(CMD_FIFO_DEPTH) + 1;
  localparam int PEND_W    = $clog2(MAX_PENDING_READS) + 1;
  localparam logic [PEND_W-1:0]    MAX_PEND    = PEND_W'(MAX_PENDING_READS);
  localparam logic [CMD_CNT_W-1:0] READY_LIMIT = CMD_CNT_W'(CMD_FIFO_DEPTH - 2);

  t_bridge_state state_q, state_d;
  logic [PEND_W-1:0] pending_q, pending_d;
  logic in_ready_q, in_ready_d;
  logic cmd_overflow_q, cmd_overflow_d;
  logic rsp_spurious_q, rsp_spurious_d;

  logic [CMD_W-1:0]     cmd_head, cmd_next;
  logic                 cmd_empty, cmd_full, cmd_pop;
  logic [CMD_CNT_W-1:0] cmd_used, cmd_used_next;
  logic                 rsp_empty, rsp_full, rsp_push, out_pop;
  logic [PEND_W-1:0]    rsp_used, rsp_used_next;
  logic [D-1:0]         rsp_dout_next;

  logic         head_is_read, head_is_32, next_is_read;
  logic [A-1:0] head_addr;
  logic [D-1:0] head_wdata;
  logic         accept, read_accept, head_eligible, next_eligible;

  assign head_is_read = cmd_head[CMD_W-1];
  assign head_is_32   = cmd_head[CMD_W-2];
  assign head_addr    = cmd_head[D +: A];
  assign head_wdata   = cmd_head[D-1:0];
  assign next_is_read = cmd_next[CMD_W-1];

  assign accept      = (state_q == ST_ISSUE) && !avmm_waitrequest;
  assign read_accept = accept && head_is_read;
  assign cmd_pop     = accept;
  assign out_pop     = !rsp_empty && out_ready;
  assign out_valid   = !rsp_empty;
  assign rsp_push    = avmm_readdatavalid && (pending_q > rsp_used);

  assign in_ready         = in_ready_q;
  assign cmd_overflow_err = cmd_overflow_q;
  assign rsp_spurious_err = rsp_spurious_q;

  logic unused_ok;
  assign unused_ok = ^{head_addr[1:0], cmd_next[CMD_W-2:0], rsp_full,
                       rsp_used_next, rsp_dout_next};

  avmm_bridge_fifo #(.WIDTH(CMD_W), .DEPTH(CMD_FIFO_DEPTH)) u_cmd_fifo (
    .clk        (clk),
    .rst        (SoftReset),
    .push       (in_valid),
    .pop        (cmd_pop),
    .din        (in_data),
    .dout       (cmd_head),
    .dout_next  (cmd_next),
    .empty      (cmd_empty),
    .full       (cmd_full),
    .usedw      (cmd_used),
    .usedw_next (cmd_used_next)
  );

  avmm_bridge_fifo #(.WIDTH(D), .DEPTH(MAX_PENDING_READS)) u_rsp_fifo (
    .clk        (clk),
    .rst        (SoftReset),
    .push       (rsp_push),
    .pop        (out_pop),
    .din        (avmm_readdata),
    .dout       (out_data),
    .dout_next  (rsp_dout_next),
    .empty      (rsp_empty),
    .full       (rsp_full),
    .usedw      (rsp_used),
    .usedw_next (rsp_used_next)
  );

  // Read credit tracking, ready/backpressure and sticky error next-state.
  always_comb begin
    pending_d = pending_q;
    case ({read_accept, out_pop})
      2'b10:   pending_d = pending_q + PEND_W'(1);
      2'b01:   pending_d = pending_q - PEND_W'(1);
      default: pending_d = pending_q;
    endcase
    in_ready_d     = (cmd_used_next <= READY_LIMIT);
    cmd_overflow_d = cmd_overflow_q | (in_valid & cmd_full & ~cmd_pop);
    rsp_spurious_d = rsp_spurious_q | (avmm_readdatavalid & ~rsp_push);
  end

  // Issue FSM and Avalon-MM outputs; only entries already stored behind the
  // head may chain back-to-back so a fresh command always sees two cycles.
  always_comb begin
    state_d         = state_q;
    avmm_read       = 1'b0;
    avmm_write      = 1'b0;
    avmm_address    = '0;
    avmm_writedata  = '0;
    avmm_byteenable = '0;
    head_eligible   = !cmd_empty && (!head_is_read || (pending_q < MAX_PEND));
    next_eligible   = (cmd_used >= CMD_CNT_W'(2)) &&
                      (!next_is_read || (pending_d < MAX_PEND));
    case (state_q)
      ST_IDLE: begin
        if (head_eligible) begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        avmm_read       = head_is_read;
        avmm_write      = !head_is_read;
        avmm_address    = {head_addr[A-1:3], 3'b000};
        avmm_writedata  = head_wdata;
        avmm_byteenable = BE_W'(ccip_byteenable(head_is_32, head_addr[2]));
        if (accept) begin
          state_d = next_eligible ? ST_ISSUE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers; reset abandons any in-flight Avalon transaction.
  always_ff @(posedge clk or posedge SoftReset) begin
    if (SoftReset) begin
      state_q        <= ST_IDLE;
      pending_q      <= '0;
      in_ready_q     <= 1'b0;
      cmd_overflow_q <= 1'b0;
      rsp_spurious_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pending_q      <= pending_d;
      in_ready_q     <= in_ready_d;
      cmd_overflow_q <= cmd_overflow_d;
      rsp_spurious_q <= rsp_spurious_d;
    end
  end

endmodule

// File: tb/tb_avst_avmm_mmio_bridge.sv
// Directed self-checking bench for avst_avmm_mmio_bridge.
module tb_avst_avmm_mmio_bridge;
  import ccip_avmm_pkg::*;

  logic        clk;
  logic        SoftReset;
  t_avst_input in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] avmm_address;
  logic        avmm_read;
  logic        avmm_write;
  logic [63:0] avmm_writedata;
  logic [7:0]  avmm_byteenable;
  logic        avmm_waitrequest;
  logic [63:0] avmm_readdata;
  logic        avmm_readdatavalid;
  logic        cmd_overflow_err;
  logic        rsp_spurious_err;

  int test_count = 0;
  int fail_count = 0;

  int          wr_count = 0;
  int          rd_count = 0;
  logic [15:0] last_wr_addr = '0;
  logic [15:0] rd_addr_log [$];

  avst_avmm_mmio_bridge dut (
    .clk                (clk),
    .SoftReset          (SoftReset),
    .in_data            (in_data),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .avmm_address       (avmm_address),
    .avmm_read          (avmm_read),
    .avmm_write         (avmm_write),
    .avmm_writedata     (avmm_writedata),
    .avmm_byteenable    (avmm_byteenable),
    .avmm_waitrequest   (avmm_waitrequest),
    .avmm_readdata      (avmm_readdata),
    .avmm_readdatavalid (avmm_readdatavalid),
    .cmd_overflow_err   (cmd_overflow_err),
    .rsp_spurious_err   (rsp_spurious_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count every Avalon transfer the slave accepts and log read addresses.
  always @(posedge clk) begin
    if (!SoftReset) begin
      if (avmm_write && !avmm_waitrequest) begin
        wr_count     <= wr_count + 1;
        last_wr_addr <= avmm_address;
      end
      if (avmm_read && !avmm_waitrequest) begin
        rd_count <= rd_count + 1;
        rd_addr_log.push_back(avmm_address);
      end
    end
  end

  function automatic t_avst_input make_cmd(input logic is_read, input logic is_32,
                                           input logic [15:0] addr,
                                           input logic [63:0] data);
    t_avst_input c;
    c.is_read    = is_read;
    c.is_32bit   = is_32;
    c.addr       = addr;
    c.write_data = data;
    return c;
  endfunction

  task automatic waitCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic valid, input t_avst_input cmd);
    in_valid = valid;
    in_data  = cmd;
    waitCycles(1);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  initial begin
    int wr_base;
    int rd_base;
    int log_base;
    SoftReset          = 1'b1;
    in_valid           = 1'b0;
    in_data            = '0;
    out_ready          = 1'b0;
    avmm_waitrequest   = 1'b0;
    avmm_readdata      = '0;
    avmm_readdatavalid = 1'b0;

    // Reset state
    waitCycles(3);
    checkOutput("rst_in_ready", {63'd0, in_ready}, 64'd0);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_rd_wr", {62'd0, avmm_read, avmm_write}, 64'd0);
    checkOutput("rst_addr_be", {40'd0, avmm_address, avmm_byteenable}, 64'd0);
    checkOutput("rst_wdata", avmm_writedata, 64'd0);
    checkOutput("rst_errs", {62'd0, cmd_overflow_err, rsp_spurious_err}, 64'd0);
    SoftReset = 1'b0;
    waitCycles(1);
    checkOutput("ready_after_rst", {63'd0, in_ready}, 64'd1);

    // 64-bit write then 32-bit low-half write, back to back
    wr_base = wr_count;
    applyStimulus(1'b1, make_cmd(1'b0, 1'b0, 16'h0010, 64'h1122334455667788));
    checkOutput("wr_latency", {63'd0, avmm_write}, 64'd0);
    applyStimulus(1'b1, make_cmd(1'b0, 1'b1, 16'h000B, 64'h00000000CAFEF00D));
    in_valid = 1'b0;
    checkOutput("wr64_write", {63'd0, avmm_write}, 64'd1);
    checkOutput("wr64_addr", {48'd0, avmm_address}, 64'h0010);
    checkOutput("wr64_be", {56'd0, avmm_byteenable}, 64'hFF);
    checkOutput("wr64_data", avmm_writedata, 64'h1122334455667788);
    waitCycles(1);
    checkOutput("wr32_write", {63'd0, avmm_write}, 64'd1);
    checkOutput("wr32_addr", {48'd0, avmm_address}, 64'h0008);
    checkOutput("wr32_be", {56'd0, avmm_byteenable}, 64'h0F);
    waitCycles(1);
    checkOutput("wr_idle", {62'd0, avmm_read, avmm_write}, 64'd0);
    checkOutput("wr_count", 64'(wr_count - wr_base), 64'd2);

    // 32-bit read under waitrequest, response held until out_ready
    rd_base = rd_count;
    applyStimulus(1'b1, make_cmd(1'b1, 1'b1, 16'h0024, 64'd0));
    in_valid = 1'b0;
    avmm_waitrequest = 1'b1;
    checkOutput("rd_latency", {63'd0, avmm_read}, 64'd0);
    waitCycles(1);
    for (int i = 0; i < 4; i++) begin
      avmm_waitrequest = (i < 3);
      checkOutput($sformatf("rd_hold_%0d", i),
                  {46'd0, avmm_read, avmm_write, avmm_address}, {46'd0, 2'b10, 16'h0020});
      checkOutput($sformatf("rd_be_%0d", i), {56'd0, avmm_byteenable}, 64'hF0);
      waitCycles(1);
    end
    avmm_waitrequest = 1'b0;
    checkOutput("rd_done", {63'd0, avmm_read}, 64'd0);
    checkOutput("rd_count", 64'(rd_count - rd_base), 64'd1);
    avmm_readdatavalid = 1'b1;
    avmm_readdata      = 64'hAABBCCDD00000000;
    checkOutput("rsp_not_yet", {63'd0, out_valid}, 64'd0);
    waitCycles(1);
    avmm_readdatavalid = 1'b0;
    checkOutput("rsp_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("rsp_data", out_data, 64'hAABBCCDD00000000);
    waitCycles(1);
    checkOutput("rsp_hold", {63'd0, out_valid}, 64'd1);
    checkOutput("rsp_hold_data", out_data, 64'hAABBCCDD00000000);
    out_ready = 1'b1;
    waitCycles(1);
    checkOutput("rsp_popped", {63'd0, out_valid}, 64'd0);

    // Six reads against a credit limit of four
    rd_base  = rd_count;
    log_base = rd_addr_log.size();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, make_cmd(1'b1, 1'b0, 16'(16'h0100 + 8 * i), 64'd0));
    end
    in_valid = 1'b0;
    waitCycles(10);
    checkOutput("credit_limit", 64'(rd_count - rd_base), 64'd4);
    for (int k = 0; k < 6; k++) begin
      avmm_readdatavalid = 1'b1;
      avmm_readdata      = 64'hD000000000000000 | 64'(k);
      waitCycles(1);
      avmm_readdatavalid = 1'b0;
      checkOutput($sformatf("credit_rsp_valid_%0d", k), {63'd0, out_valid}, 64'd1);
      checkOutput($sformatf("credit_rsp_data_%0d", k), out_data,
                  64'hD000000000000000 | 64'(k));
      waitCycles(5);
      checkOutput($sformatf("credit_issued_%0d", k), 64'(rd_count - rd_base),
                  64'((k + 5 > 6) ? 6 : k + 5));
    end
    for (int i = 0; i < 6; i++) begin
      if (log_base + i < rd_addr_log.size()) begin
        checkOutput($sformatf("rd_order_%0d", i), {48'd0, rd_addr_log[log_base + i]},
                    64'(16'h0100 + 8 * i));
      end else begin
        checkOutput($sformatf("rd_order_missing_%0d", i), 64'd0, 64'd1);
      end
    end

    // Overflow: push every cycle while the slave stalls
    wr_base = wr_count;
    avmm_waitrequest = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, make_cmd(1'b0, 1'b0, 16'(16'h0200 + 8 * i), 64'(i)));
      checkOutput($sformatf("ovf_ready_%0d", i), {63'd0, in_ready},
                  (i + 1 >= 7) ? 64'd0 : 64'd1);
      checkOutput($sformatf("ovf_err_%0d", i), {63'd0, cmd_overflow_err},
                  (i >= 8) ? 64'd1 : 64'd0);
    end
    in_valid = 1'b0;
    avmm_waitrequest = 1'b0;
    waitCycles(12);
    checkOutput("ovf_drained", 64'(wr_count - wr_base), 64'd8);
    checkOutput("ovf_last_addr", {48'd0, last_wr_addr}, 64'h0238);
    checkOutput("ovf_sticky", {63'd0, cmd_overflow_err}, 64'd1);
    checkOutput("ovf_ready_back", {63'd0, in_ready}, 64'd1);

    // Spurious readdatavalid with nothing pending
    avmm_readdatavalid = 1'b1;
    avmm_readdata      = 64'h5555AAAA5555AAAA;
    waitCycles(1);
    avmm_readdatavalid = 1'b0;
    checkOutput("spur_no_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("spur_err", {63'd0, rsp_spurious_err}, 64'd1);

    // Reset in the middle of a stalled issue with three queued behind it
    wr_base = wr_count;
    avmm_waitrequest = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, make_cmd(1'b0, 1'b0, 16'(16'h0300 + 8 * i), 64'(i)));
    end
    in_valid = 1'b0;
    checkOutput("mid_issue", {63'd0, avmm_write}, 64'd1);
    SoftReset = 1'b1;
    #1;
    checkOutput("rst_mid_rd_wr", {62'd0, avmm_read, avmm_write}, 64'd0);
    checkOutput("rst_mid_errs", {62'd0, cmd_overflow_err, rsp_spurious_err}, 64'd0);
    waitCycles(1);
    checkOutput("rst_mid_next", {61'd0, avmm_read, avmm_write, out_valid}, 64'd0);
    checkOutput("rst_mid_ready", {63'd0, in_ready}, 64'd0);
    SoftReset = 1'b0;
    avmm_waitrequest = 1'b0;
    waitCycles(1);
    checkOutput("rst_mid_ready_up", {63'd0, in_ready}, 64'd1);
    waitCycles(5);
    checkOutput("rst_mid_no_residual", 64'(wr_count - wr_base), 64'd0);
    checkOutput("rst_mid_quiet", {62'd0, avmm_read, avmm_write}, 64'd0);
    avmm_readdatavalid = 1'b1;
    waitCycles(1);
    avmm_readdatavalid = 1'b0;
    checkOutput("rst_late_rdv_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_late_rdv_err", {63'd0, rsp_spurious_err}, 64'd1);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
